// File: rtl/ins_mem_block.sv
// Block-read instruction memory.
// Returns one BLOCK_WORDS x 32-bit block per request after a programmable
// latency, driving BUSYWAIT while the access is outstanding. Supports request
// abort (READ dropped while busy), out-of-range detection on the latched
// block address, and a word-wide preload port usable at any time.
module ins_mem_block #(
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_BYTES   = 1024,
  parameter int LATENCY     = 5,
  parameter int ADDR_WIDTH  = 28
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic [ADDR_WIDTH-1:0]          ADDRESS,
  output logic [32*BLOCK_WORDS-1:0]      INSTRUCTION_OUT,
  output logic                           BUSYWAIT,
  output logic                           READ_ERROR,
  input  logic                           LOAD_EN,
  input  logic [$clog2(MEM_BYTES)-3:0]   LOAD_ADDR,
  input  logic [31:0]                    LOAD_DATA
);

  localparam int BLOCK_BYTES = 4 * BLOCK_WORDS;
  localparam int MEM_WORDS   = MEM_BYTES / 4;
  localparam int MEM_BLOCKS  = MEM_BYTES / BLOCK_BYTES;
  localparam int WORD_AW     = $clog2(MEM_WORDS);
  localparam int BLK_AW      = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
  localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int OUT_W       = 32 * BLOCK_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Storage: word-organised, byte 0 of each word in bits [7:0].
  logic [31:0] mem_q [MEM_WORDS];

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    err_q, err_d;

  logic [BLK_AW-1:0]       blk_idx;
  logic [OUT_W-1:0]        block_data;
  logic                    in_range;

  // Range test on the full latched address, so high address bits are never lost.
  assign in_range = (64'(addr_q) < 64'(MEM_BLOCKS));
  assign blk_idx  = addr_q[BLK_AW-1:0];

  // Gather the addressed block from storage (little-endian word order).
  always_comb begin
    block_data = '0;
    for (int j = 0; j < BLOCK_WORDS; j++) begin
      block_data[32*j +: 32] = mem_q[WORD_AW'(int'(blk_idx) * BLOCK_WORDS + j)];
    end
  end

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    out_d   = out_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (READ) begin
          addr_d  = ADDRESS;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!READ) begin
          // Abort: results from the previous access stay visible.
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          out_d   = in_range ? block_data : '0;
          err_d   = !in_range;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access FSM registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    // NOTE: non-blocking assignments so all flops sample pre-edge values;
    // this is also what makes a same-edge preload invisible to a capture.
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Preload write port, active in any FSM state.
  always_ff @(posedge CLOCK) begin
    // NOTE: storage is deliberately not reset; program contents survive RESET
    // and a reset port would prevent mapping onto RAM macros.
    if (LOAD_EN) begin
      mem_q[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  assign BUSYWAIT        = !RESET && (((state_q == IDLE) && READ) || (state_q == BUSY));
  assign INSTRUCTION_OUT = out_q;
  assign READ_ERROR      = err_q;

endmodule

// File: tb/tb_ins_mem_block.sv
// Self-checking bench for ins_mem_block: scoreboard of expected blocks pushed
// when a read is issued and popped when the DUT finishes the access.
module tb_ins_mem_block;

  localparam int BW  = 4;
  localparam int MB  = 1024;
  localparam int LAT = 5;
  localparam int AW  = 28;
  localparam int LW  = $clog2(MB) - 2;
  localparam int OW  = 32 * BW;
  localparam int NBLK = MB / (4 * BW);
  localparam int MAXW = 40;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          read;
  logic [AW-1:0] address;
  logic [OW-1:0] instruction_out;
  logic          busywait;
  logic          read_error;
  logic          load_en;
  logic [LW-1:0] load_addr;
  logic [31:0]   load_data;

  logic [OW-1:0] io_l1;
  logic          bw_l1;
  logic          err_l1;

  logic [31:0]   model [MB/4];
  exp_t          sb [$];
  logic [OW-1:0] last_out;
  logic          last_err;
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clock = ~clock;

  ins_mem_block #(.BLOCK_WORDS(BW), .MEM_BYTES(MB), .LATENCY(LAT), .ADDR_WIDTH(AW)) u_dut (
    .CLOCK(clock), .RESET(reset), .READ(read), .ADDRESS(address),
    .INSTRUCTION_OUT(instruction_out), .BUSYWAIT(busywait), .READ_ERROR(read_error),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  // Second instance covering the single-cycle latency corner; shares stimulus.
  ins_mem_block #(.BLOCK_WORDS(BW), .MEM_BYTES(MB), .LATENCY(1), .ADDR_WIDTH(AW)) u_dut_l1 (
    .CLOCK(clock), .RESET(reset), .READ(read), .ADDRESS(address),
    .INSTRUCTION_OUT(io_l1), .BUSYWAIT(bw_l1), .READ_ERROR(err_l1),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  function automatic exp_t exp_block(input logic [AW-1:0] a);
    exp_t e;
    e.data = '0;
    e.err  = 1'b1;
    if (a < AW'(NBLK)) begin
      e.err = 1'b0;
      for (int j = 0; j < BW; j++) e.data[32*j +: 32] = model[int'(a) * BW + j];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = LW'(a);
    load_data = d;
    tick();
    load_en   = 1'b0;
    model[a]  = d;
  endtask

  // One complete read on the LATENCY=LAT instance; optionally preloads a word
  // on the capture edge, optionally leaves READ high at the end (in DONE).
  task automatic do_read(input string name, input logic [AW-1:0] a, input bit hold,
                         input bit collide, input int c_addr, input logic [31:0] c_data);
    int   n;
    exp_t e;
    read    = 1'b1;
    address = a;
    sb.push_back(exp_block(a));
    #1;
    n_checks++;
    if (busywait !== 1'b1) $display("FAIL %s busywait_on_request got=%b want=1", name, busywait);
    else n_pass++;
    n = 0;
    do begin
      tick();
      n++;
      if (collide && n == LAT) begin
        load_en = 1'b1; load_addr = LW'(c_addr); load_data = c_data;
      end
    end while (busywait && n < MAXW);
    if (collide) begin
      load_en = 1'b0;
      model[c_addr] = c_data;
    end
    n_checks++;
    if (n !== LAT + 1) $display("FAIL %s busy_edges got=%0d want=%0d", name, n, LAT + 1);
    else n_pass++;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard_empty got=0 want=1 entry", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (instruction_out !== e.data) $display("FAIL %s data got=%h want=%h", name, instruction_out, e.data);
      else n_pass++;
      n_checks++;
      if (read_error !== e.err) $display("FAIL %s read_error got=%b want=%b", name, read_error, e.err);
      else n_pass++;
      last_out = e.data;
      last_err = e.err;
    end
    if (!hold) begin
      read = 1'b0;
      tick();
      n_checks++;
      if (busywait !== 1'b0) $display("FAIL %s busywait_after_done got=%b want=0", name, busywait);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b1; address = '0;
    tick();
    tick();
    n_checks++;
    if (busywait !== 1'b0) $display("FAIL reset busywait got=%b want=0", busywait);
    else n_pass++;
    n_checks++;
    if (instruction_out !== '0) $display("FAIL reset instruction_out got=%h want=0", instruction_out);
    else n_pass++;
    n_checks++;
    if (read_error !== 1'b0) $display("FAIL reset read_error got=%b want=0", read_error);
    else n_pass++;
    read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    for (int i = 0; i < MB/4; i++) load_word(i, $urandom);
    load_word(0, 32'h0000_0013);
    load_word(1, 32'h0010_0093);
    load_word(2, 32'h0020_0113);
    load_word(3, 32'h0030_0193);
    do_read("preload_blk0", 0, 1'b0, 1'b0, 0, 32'h0);
    n_checks++;
    if (last_out !== 128'h00300193_00200113_00100093_00000013 || instruction_out !== last_out)
      $display("FAIL preload_literal got=%h want=%h", instruction_out, 128'h00300193_00200113_00100093_00000013);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    do_read("b2b_first", 0, 1'b1, 1'b0, 0, 32'h0);
    address = 1;
    sb.push_back(exp_block(1));
    n = 0;
    do begin
      tick();
      n++;
    end while (busywait && n < MAXW);
    n_checks++;
    if (n !== LAT + 2) $display("FAIL b2b period got=%0d want=%0d", n, LAT + 2);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (instruction_out !== e.data) $display("FAIL b2b data got=%h want=%h", instruction_out, e.data);
    else n_pass++;
    last_out = e.data;
    last_err = e.err;
    read = 1'b0;
    tick();
    n_checks++;
    if (busywait !== 1'b0) $display("FAIL b2b busywait_idle got=%b want=0", busywait);
    else n_pass++;
  endtask

  task automatic test_abort();
    read = 1'b1; address = 5;
    tick();
    tick();
    tick();
    read = 1'b0;
    #1;
    n_checks++;
    if (busywait !== 1'b1) $display("FAIL abort busywait_in_busy got=%b want=1", busywait);
    else n_pass++;
    tick();
    n_checks++;
    if (busywait !== 1'b0) $display("FAIL abort busywait got=%b want=0", busywait);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (instruction_out !== last_out) $display("FAIL abort data_kept got=%h want=%h", instruction_out, last_out);
    else n_pass++;
    n_checks++;
    if (read_error !== last_err) $display("FAIL abort err_kept got=%b want=%b", read_error, last_err);
    else n_pass++;
  endtask

  task automatic test_range();
    do_read("range_64", AW'(NBLK), 1'b0, 1'b0, 0, 32'h0);
    do_read("range_63", AW'(NBLK - 1), 1'b0, 1'b0, 0, 32'h0);
    do_read("range_high_bit", 28'h400_0000, 1'b0, 1'b0, 0, 32'h0);
    do_read("range_clear", 2, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_addr_hold();
    int   n;
    exp_t e;
    read = 1'b1; address = 3;
    sb.push_back(exp_block(3));
    tick();
    tick();
    address = 7;
    n = 2;
    while (busywait && n < MAXW) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    n_checks++;
    if (instruction_out !== e.data) $display("FAIL addr_hold data got=%h want=%h", instruction_out, e.data);
    else n_pass++;
    last_out = e.data;
    last_err = e.err;
    read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    read = 1'b1; address = 4;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (busywait !== 1'b0) $display("FAIL reset_mid busywait_forced got=%b want=0", busywait);
    else n_pass++;
    tick();
    n_checks++;
    if (instruction_out !== '0) $display("FAIL reset_mid instruction_out got=%h want=0", instruction_out);
    else n_pass++;
    reset = 1'b0;
    read  = 1'b0;
    tick();
    n_checks++;
    if (busywait !== 1'b0) $display("FAIL reset_mid idle_busywait got=%b want=0", busywait);
    else n_pass++;
    do_read("reset_mid_mem_intact", 0, 1'b0, 1'b0, 0, 32'h0);
  endtask

  task automatic test_load_collision();
    do_read("collide_old", 0, 1'b0, 1'b1, 2, 32'hDEAD_BEEF);
    do_read("collide_new", 0, 1'b0, 1'b0, 0, 32'h0);
    n_checks++;
    if (instruction_out[95:64] !== 32'hDEAD_BEEF)
      $display("FAIL collide_word2 got=%h want=deadbeef", instruction_out[95:64]);
    else n_pass++;
  endtask

  task automatic test_latency1();
    exp_t e;
    read = 1'b1; address = 1;
    sb.push_back(exp_block(1));
    #1;
    n_checks++;
    if (bw_l1 !== 1'b1) $display("FAIL lat1 busywait_request got=%b want=1", bw_l1);
    else n_pass++;
    tick();
    n_checks++;
    if (bw_l1 !== 1'b1) $display("FAIL lat1 busywait_busy got=%b want=1", bw_l1);
    else n_pass++;
    tick();
    n_checks++;
    if (bw_l1 !== 1'b0) $display("FAIL lat1 busywait_done got=%b want=0", bw_l1);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (io_l1 !== e.data) $display("FAIL lat1 data got=%h want=%h", io_l1, e.data);
    else n_pass++;
    n_checks++;
    if (err_l1 !== e.err) $display("FAIL lat1 read_error got=%b want=%b", err_l1, e.err);
    else n_pass++;
    read = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; address = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    last_out = '0; last_err = 1'b0;
    test_reset();
    test_preload_read();
    test_back_to_back();
    test_abort();
    test_range();
    test_addr_hold();
    test_reset_mid();
    test_load_collision();
    test_latency1();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ins_mem_block.md
# ins_mem_block

Parametrised block-read instruction memory: the successor to the fixed 16-byte, fixed-delay instruction memory. It returns one cache-line-sized block of BLOCK_WORDS little-endian 32-bit words per request. A programmable-latency FSM drives the BUSYWAIT handshake, and the block adds request abort, out-of-range detection and a word-wide preload port for boot/test. It sits between the instruction cache refill logic and the backing program store.

## Interface
- BLOCK_WORDS, 4: 32-bit words per block; power of 2, ≥1. BLOCK_BYTES = 4·BLOCK_WORDS.
- MEM_BYTES, 1024: storage size in bytes; multiple of BLOCK_BYTES.
- LATENCY, 5: access latency in clock cycles; ≥1.
- ADDR_WIDTH, 28: width of the block address.
- CLOCK  in  1  sole clock, rising edge.
- RESET  in  1  reset; synchronous and active-high (the one clock; polarity and synchronicity fixed).
- READ  in  1  block read request; held high until BUSYWAIT falls.
- ADDRESS  in  ADDR_WIDTH  block address; byte address = ADDRESS·BLOCK_BYTES.
- INSTRUCTION_OUT  out  32·BLOCK_WORDS  returned block; byte i at bits [8i+7:8i].
- BUSYWAIT  out  1  requester must stall while high.
- READ_ERROR  out  1  last completed read was out of range.
- LOAD_EN  in  1  preload write enable.
- LOAD_ADDR  in  $clog2(MEM_BYTES)-2  word address for preload.
- LOAD_DATA  in  32  preload word, little-endian.

## Operation
- Reset values:
  - state IDLE, counter 0.
  - INSTRUCTION_OUT 0, READ_ERROR 0.
  - BUSYWAIT 0 for every cycle RESET is high.
  - Memory contents are not cleared.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - READ high at an edge latches ADDRESS into an internal register, loads counter = LATENCY-1, and moves to BUSY.
- BUSY:
  - READ low at an edge aborts. Next state is IDLE; INSTRUCTION_OUT and READ_ERROR are unchanged.
  - Otherwise, with counter ≠ 0, the counter decrements.
  - With counter = 0, the block at the latched address is captured into INSTRUCTION_OUT, READ_ERROR is updated, and the state moves to DONE.
- DONE:
  - Lasts exactly one cycle, then unconditionally returns to IDLE.
  - READ still high in the following IDLE cycle starts a new access, with ADDRESS sampled afresh.
- BUSYWAIT is combinational: (state==IDLE && READ) || state==BUSY, forced 0 under RESET. It is 0 in DONE.
- Range check:
  - The latched address is in range iff latched address < MEM_BYTES/BLOCK_BYTES, compared at full ADDR_WIDTH with no truncation.
  - An out-of-range capture writes INSTRUCTION_OUT = 0 and READ_ERROR = 1.
  - An in-range capture writes READ_ERROR = 0.
- Preload:
  - LOAD_EN high at an edge writes LOAD_DATA bytes 0..3 to byte addresses 4·LOAD_ADDR .. 4·LOAD_ADDR+3.
  - Preload is accepted in any state, independent of READ.
- Address change in BUSY has no effect, because the latched address is used.
- RESET mid-access aborts to IDLE with the reset values above.

## Timing
- Request sampled at edge k. Capture occurs at edge k+LATENCY, and INSTRUCTION_OUT is valid from then.
- BUSYWAIT is high from READ rise through edge k+LATENCY, then low for exactly one cycle (DONE).
- Minimum back-to-back period with READ held high is LATENCY+2 cycles.
- Simultaneous LOAD_EN and capture on the same word: capture returns the pre-write data (read-before-write). The next read sees the new data.
- LATENCY=1: BUSY lasts one cycle; capture at k+1.
- Highest block (ADDRESS = MEM_BYTES/BLOCK_BYTES-1) is in range; the next address up is an error.

## Test plan
- Preload words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; READ, ADDRESS=0, LATENCY=5 -> BUSYWAIT high for 5 edges, then INSTRUCTION_OUT = 0x00300193_00200113_00100093_00000013, READ_ERROR=0, BUSYWAIT=0 for one cycle.
- READ held high with ADDRESS stepped 0→1 during DONE -> second access starts the next cycle; the block-1 data appears LATENCY+2 cycles after the first capture.
- READ dropped in the 3rd BUSY cycle -> return to IDLE, INSTRUCTION_OUT keeps its previous value, BUSYWAIT=0.
- ADDRESS = 64 (MEM_BYTES=1024, BLOCK_WORDS=4) -> after LATENCY, INSTRUCTION_OUT=0 and READ_ERROR=1; a following ADDRESS=63 read clears READ_ERROR.
- RESET asserted on the 2nd BUSY cycle -> next cycle INSTRUCTION_OUT=0, BUSYWAIT=0, state IDLE; preloaded memory is still intact on the next read.
- LOAD_EN writing 0xDEADBEEF to word 2 on the capture edge of a block-0 read -> the old word 2 is returned; an immediate re-read returns 0xDEADBEEF at bits [95:64].
